// File: rtl/alu_ctrl_decoder.sv
// -----------------------------------------------------------------------------
// alu_ctrl_decoder
//
// Decodes RV32I instruction words into ALU control fields and hands them to the
// ALU stage through a 2-entry valid/ready buffer (output register plus skid
// register). in_ready is derived purely from registered occupancy, so there is
// no combinational path from out_ready back to in_ready.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset (empties both entries)
//   in_valid     instruction word valid
//   in_ready     block can accept an instruction (0 only when both entries full)
//   in_instr     RV32I instruction word
//   out_valid    decoded entry valid
//   out_ready    ALU stage accepts the entry
//   out_instr    instruction word, unchanged
//   alu_ctrl     ALU operation code
//   alu_src_imm  operand B is the immediate (1) or rs2 (0)
//   illegal      entry is an undecodable instruction
//   err_count    (only with ALU_DECODE_ERRCNT_EN) saturating count of illegal
//                entries issued downstream
//
// Optional feature macro: ALU_DECODE_ERRCNT_EN
// -----------------------------------------------------------------------------
module alu_ctrl_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [3:0]  alu_ctrl,
    output logic        alu_src_imm,
    output logic        illegal
`ifdef ALU_DECODE_ERRCNT_EN
    ,
    output logic [7:0]  err_count
`endif
);

    // Opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [3:0]  ctrl;
        logic        src_imm;
        logic        illegal;
    } entry_t;

    // Pure decode of one instruction word into a valid buffer entry.
    function automatic entry_t decode(input logic [31:0] instr);
        entry_t     e;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       bad;
        f3        = instr[14:12];
        f7        = instr[31:25];
        bad       = 1'b0;
        e         = '0;
        e.valid   = 1'b1;
        e.instr   = instr;
        e.ctrl    = ALU_ADD;
        e.src_imm = 1'b0;
        case (instr[6:0])
            OPC_OP: begin
                // funct7[5] selects SUB/SRA; only legal alongside ADD/SRL funct3.
                e.ctrl = {f7[5], f3};
                if (!((f7 == F7_ZERO) ||
                      ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)))))
                    bad = 1'b1;
            end
            OPC_OP_IMM: begin
                e.src_imm = 1'b1;
                e.ctrl    = {1'b0, f3};
                if (f3 == 3'b001) begin
                    bad = (f7 != F7_ZERO);
                end else if (f3 == 3'b101) begin
                    if (f7 == F7_ALT)
                        e.ctrl = ALU_SRA;
                    else if (f7 != F7_ZERO)
                        bad = 1'b1;
                end
            end
            OPC_BRANCH: begin
                // Branch compare: equality via SUB, signed/unsigned via SLT/SLTU.
                case (f3)
                    3'b000, 3'b001: e.ctrl = ALU_SUB;
                    3'b100, 3'b101: e.ctrl = ALU_SLT;
                    3'b110, 3'b111: e.ctrl = ALU_SLTU;
                    default:        bad    = 1'b1;
                endcase
            end
            OPC_LOAD, OPC_STORE, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: begin
                e.ctrl    = ALU_ADD;
                e.src_imm = 1'b1;
            end
            default: bad = 1'b1;
        endcase
        // Illegal entries still travel downstream with neutral control fields.
        if (bad) begin
            e.ctrl    = ALU_ADD;
            e.src_imm = 1'b0;
            e.illegal = 1'b1;
        end
        return e;
    endfunction

    entry_t out_q, out_d;
    entry_t skid_q, skid_d;
    entry_t new_entry;
    logic   accept;
    logic   issue;
    logic   in_ready_int;

`ifdef ALU_DECODE_ERRCNT_EN
    logic [7:0] err_count_q, err_count_d;
`endif

    // The skid register is only ever occupied while the output register is.
    assign in_ready_int = !(out_q.valid && skid_q.valid);

    // NOTE: every always_comb target gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        out_d     = out_q;
        skid_d    = skid_q;
        new_entry = decode(in_instr);
        accept    = in_valid && in_ready_int;
        issue     = out_q.valid && out_ready;

        if (issue) begin
            if (skid_q.valid) begin
                // Full: no accept is possible; skid slides into the output slot.
                out_d        = skid_q;
                skid_d.valid = 1'b0;
            end else if (accept) begin
                out_d = new_entry;
            end else begin
                out_d.valid = 1'b0;
            end
        end else if (accept) begin
            if (out_q.valid)
                skid_d = new_entry;
            else
                out_d = new_entry;
        end
    end

`ifdef ALU_DECODE_ERRCNT_EN
    always_comb begin
        err_count_d = err_count_q;
        if (issue && out_q.illegal && (err_count_q != 8'hFF))
            err_count_d = err_count_q + 8'd1;
    end
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its _d value from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the data fields are reset too, not just the valid bits,
            // because the output fields must read as zero after reset.
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            out_q  <= out_d;
            skid_q <= skid_d;
        end
    end

`ifdef ALU_DECODE_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            err_count_q <= 8'd0;
        else
            err_count_q <= err_count_d;
    end

    assign err_count = err_count_q;
`endif

    assign in_ready    = in_ready_int;
    assign out_valid   = out_q.valid;
    assign out_instr   = out_q.instr;
    assign alu_ctrl    = out_q.ctrl;
    assign alu_src_imm = out_q.src_imm;
    assign illegal     = out_q.illegal;

endmodule

// File: tb/tb_alu_ctrl_decoder.sv
// -----------------------------------------------------------------------------
// tb_alu_ctrl_decoder
//
// Self-checking bench for alu_ctrl_decoder. Inputs change and outputs are
// sampled at the falling edge; every accepted word pushes its expected decode
// onto a scoreboard queue, and every issued entry pops and compares.
// -----------------------------------------------------------------------------
module tb_alu_ctrl_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [3:0]  alu_ctrl;
    logic        alu_src_imm;
    logic        illegal;
`ifdef ALU_DECODE_ERRCNT_EN
    logic [7:0]  err_count;
`endif

    int checks = 0;
    int errors = 0;
    int model_err = 0;

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  ctrl;
        logic        src;
        logic        ill;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    alu_ctrl_decoder dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .alu_ctrl    (alu_ctrl),
        .alu_src_imm (alu_src_imm),
        .illegal     (illegal)
`ifdef ALU_DECODE_ERRCNT_EN
        ,
        .err_count   (err_count)
`endif
    );

    // Reference decode, written as a flat instruction-class table.
    function automatic exp_t model(input logic [31:0] w);
        exp_t       e;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op      = w[6:0];
        f3      = w[14:12];
        f7      = w[31:25];
        e.instr = w;
        e.ctrl  = 4'b0000;
        e.src   = 1'b0;
        e.ill   = 1'b0;
        if (op == 7'b0110011) begin
            if (f7 == 7'h00)                      e.ctrl = {1'b0, f3};
            else if (f7 == 7'h20 && f3 == 3'b000) e.ctrl = 4'b1000;
            else if (f7 == 7'h20 && f3 == 3'b101) e.ctrl = 4'b1101;
            else                                  e.ill  = 1'b1;
        end else if (op == 7'b0010011) begin
            e.src = 1'b1;
            if (f3 == 3'b001) begin
                if (f7 == 7'h00) e.ctrl = 4'b0001; else e.ill = 1'b1;
            end else if (f3 == 3'b101) begin
                if (f7 == 7'h00)      e.ctrl = 4'b0101;
                else if (f7 == 7'h20) e.ctrl = 4'b1101;
                else                  e.ill  = 1'b1;
            end else begin
                e.ctrl = {1'b0, f3};
            end
        end else if (op == 7'b1100011) begin
            if (f3 == 3'b000 || f3 == 3'b001)      e.ctrl = 4'b1000;
            else if (f3 == 3'b100 || f3 == 3'b101) e.ctrl = 4'b0010;
            else if (f3 == 3'b110 || f3 == 3'b111) e.ctrl = 4'b0011;
            else                                   e.ill  = 1'b1;
        end else if (op == 7'b0000011 || op == 7'b0100011 || op == 7'b1101111 ||
                     op == 7'b1100111 || op == 7'b0110111 || op == 7'b0010111) begin
            e.src = 1'b1;
        end else begin
            e.ill = 1'b1;
        end
        if (e.ill) begin
            e.ctrl = 4'b0000;
            e.src  = 1'b0;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [6:0]  ops [10];
        logic [31:0] w;
        int          r;
        ops = '{7'b0110011, 7'b0010011, 7'b1100011, 7'b0000011, 7'b0100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0000000};
        w = $urandom;
        w[6:0] = ops[$urandom_range(0, 9)];
        r = $urandom_range(0, 3);
        if (r == 0)      w[31:25] = 7'h00;
        else if (r == 1) w[31:25] = 7'h20;
        return w;
    endfunction

    // One clock: account for the handshakes about to happen, then advance to
    // the next falling edge.
    task automatic tick();
        logic acc;
        logic iss;
        exp_t e;
        acc = in_valid && in_ready;
        iss = out_valid && out_ready;
        checks++;
        if (in_ready !== (sb.size() < 2)) begin
            errors++;
            $display("FAIL in_ready_occupancy: got %b expected %b", in_ready, (sb.size() < 2));
        end
        checks++;
        if (out_valid !== (sb.size() > 0)) begin
            errors++;
            $display("FAIL out_valid_occupancy: got %b expected %b", out_valid, (sb.size() > 0));
        end
        if (iss) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL issue_unexpected: got entry %h expected none", out_instr);
            end else begin
                e = sb.pop_front();
                if ({out_instr, alu_ctrl, alu_src_imm, illegal} !== {e.instr, e.ctrl, e.src, e.ill}) begin
                    errors++;
                    $display("FAIL issue_entry: got %h/%b/%b/%b expected %h/%b/%b/%b",
                             out_instr, alu_ctrl, alu_src_imm, illegal, e.instr, e.ctrl, e.src, e.ill);
                end
                if (e.ill && model_err < 255) model_err++;
            end
        end
        if (acc) sb.push_back(model(in_instr));
        @(posedge clk);
        @(negedge clk);
`ifdef ALU_DECODE_ERRCNT_EN
        checks++;
        if (err_count !== model_err[7:0]) begin
            errors++;
            $display("FAIL err_count_track: got %0d expected %0d", err_count, model_err);
        end
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        model_err = 0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4 && sb.size() > 0; i++) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if ({out_valid, in_ready, alu_ctrl, alu_src_imm, illegal, out_instr} !==
            {1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL %s: got v=%b r=%b ctrl=%b imm=%b ill=%b instr=%h expected v=0 r=1 all zero",
                     name, out_valid, in_ready, alu_ctrl, alu_src_imm, illegal, out_instr);
        end
`ifdef ALU_DECODE_ERRCNT_EN
        checks++;
        if (err_count !== 8'd0) begin
            errors++;
            $display("FAIL %s_err_count: got %0d expected 0", name, err_count);
        end
`endif
    endtask

    task automatic check_out(input string name, input logic [3:0] ctrl,
                             input logic src, input logic ill);
        checks++;
        if ({out_valid, alu_ctrl, alu_src_imm, illegal} !== {1'b1, ctrl, src, ill}) begin
            errors++;
            $display("FAIL %s: got v=%b ctrl=%b imm=%b ill=%b expected v=1 ctrl=%b imm=%b ill=%b",
                     name, out_valid, alu_ctrl, alu_src_imm, illegal, ctrl, src, ill);
        end
    endtask

    task automatic test_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_instr  = 32'h0;
        do_reset();
        check_idle("reset_state");
    endtask

    task automatic test_rtype();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h40B50533;
        tick();
        in_valid = 1'b0;
        check_out("rtype_sub", 4'b1000, 1'b0, 1'b0);
        drain();
    endtask

    task automatic test_itype();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h4035D513;
        tick();
        check_out("itype_srai", 4'b1101, 1'b1, 1'b0);
        in_instr = 32'h00A00093;
        tick();
        in_valid = 1'b0;
        check_out("itype_addi", 4'b0000, 1'b1, 1'b0);
        drain();
    endtask

    task automatic test_branch();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h00B56463;
        tick();
        check_out("branch_bltu", 4'b0011, 1'b0, 1'b0);
        in_instr = 32'h00B52463;
        tick();
        in_valid = 1'b0;
        check_out("branch_f3_010", 4'b0000, 1'b0, 1'b1);
        drain();
    endtask

    task automatic test_backpressure();
        logic [31:0] w [3];
        logic [31:0] got [3];
        int          n;
        int          cyc;
        logic        acc;
        w = '{32'h00A00093, 32'h40B50533, 32'h00B56463};
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = w[0];
        tick();
        in_instr = w[1];
        tick();
        in_instr = w[2];
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({in_ready, out_valid, out_instr, alu_ctrl, alu_src_imm} !==
                {1'b0, 1'b1, w[0], 4'b0000, 1'b1}) begin
                errors++;
                $display("FAIL bp_stall_%0d: got r=%b v=%b instr=%h ctrl=%b imm=%b expected r=0 v=1 instr=%h ctrl=0000 imm=1",
                         i, in_ready, out_valid, out_instr, alu_ctrl, alu_src_imm, w[0]);
            end
            tick();
        end
        out_ready = 1'b1;
        n   = 0;
        cyc = 0;
        while (n < 3 && cyc < 10) begin
            if (out_valid && out_ready) begin
                got[n] = out_instr;
                n++;
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) in_valid = 1'b0;
            cyc++;
        end
        checks++;
        if (n != 3 || cyc != 3) begin
            errors++;
            $display("FAIL bp_release_rate: got %0d issues in %0d cycles expected 3 in 3", n, cyc);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= n || got[i] !== w[i]) begin
                errors++;
                $display("FAIL bp_order_%0d: got %h expected %h", i, (i < n) ? got[i] : 32'hx, w[i]);
            end
        end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_instr  = rand_word();
            tick();
        end
        drain();
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h40B50533;
        tick();
        in_instr = 32'h00000000;
        tick();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_full: got in_ready=%b expected 0", in_ready);
        end
        // Offer a handshake on both sides during the reset edge.
        out_ready = 1'b1;
        in_instr  = 32'h00A00093;
        do_reset();
        in_valid = 1'b0;
        check_idle("midreset_empty");
        tick();
        check_idle("midreset_no_ghost");
    endtask

`ifdef ALU_DECODE_ERRCNT_EN
    task automatic test_errcnt();
        int issued;
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h00000000;
        issued    = 0;
        for (int i = 0; i < 400 && issued < 300; i++) begin
            if (out_valid && out_ready) issued++;
            if (issued == 299) in_valid = 1'b0;
            tick();
        end
        drain();
        checks++;
        if (err_count !== 8'd255) begin
            errors++;
            $display("FAIL errcnt_saturate: got %0d expected 255", err_count);
        end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_instr  = 32'h0;
        @(negedge clk);
        test_reset();
        test_rtype();
        test_itype();
        test_branch();
        test_backpressure();
        test_random();
        test_reset_midflight();
`ifdef ALU_DECODE_ERRCNT_EN
        test_errcnt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
